// File: rtl/bp_dram_app_model_if.sv
// MIG-style application interface bundle between the cache-to-DRAM controller
// (master) and the DRAM model (slave).
//
// Handshake rules for every channel:
//   - The command channel (app_en_i/app_rdy_o) and the write-data channel
//     (app_wdf_wren_i/app_wdf_rdy_o) transfer on a rising clock edge where
//     both valid and ready are high.
//   - Ready depends only on slave-side registered state, never on the
//     master's valid, so a master may wait for ready before raising valid.
//   - The read-data channel (app_rd_data_valid_o) has no backpressure: a beat
//     is delivered on every cycle where valid is high.
//
// Signals:
//   app_en_i/app_rdy_o/app_cmd_i/app_addr_i     command channel
//   app_wdf_wren_i/app_wdf_data_i/app_wdf_mask_i/app_wdf_end_i/app_wdf_rdy_o
//                                               write-data channel
//   app_rd_data_valid_o/app_rd_data_o/app_rd_data_end_o
//                                               read-data return
interface bp_dram_app_model_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  logic                      app_en_i;
  logic                      app_rdy_o;
  logic [2:0]                app_cmd_i;
  logic [addr_width_p-1:0]   app_addr_i;
  logic                      app_wdf_wren_i;
  logic [data_width_p-1:0]   app_wdf_data_i;
  logic [data_width_p/8-1:0] app_wdf_mask_i;
  logic                      app_wdf_end_i;
  logic                      app_wdf_rdy_o;
  logic                      app_rd_data_valid_o;
  logic [data_width_p-1:0]   app_rd_data_o;
  logic                      app_rd_data_end_o;

  modport master (
    output app_en_i, app_cmd_i, app_addr_i,
    output app_wdf_wren_i, app_wdf_data_i, app_wdf_mask_i, app_wdf_end_i,
    input  app_rdy_o, app_wdf_rdy_o,
    input  app_rd_data_valid_o, app_rd_data_o, app_rd_data_end_o
  );

  modport slave (
    input  app_en_i, app_cmd_i, app_addr_i,
    input  app_wdf_wren_i, app_wdf_data_i, app_wdf_mask_i, app_wdf_end_i,
    output app_rdy_o, app_wdf_rdy_o,
    output app_rd_data_valid_o, app_rd_data_o, app_rd_data_end_o
  );
endinterface

// File: rtl/bp_dram_app_model.sv
// Behavioural DRAM controller model presenting a MIG-style application
// interface. Commands and write beats are queued separately; a single in-order
// engine services one burst at a time against an internal beat array. Reads
// return through a fixed-latency pipeline. Calibration and UI reset are
// modelled with a saturating counter started at reset release.
//
// Ports:
//   clk_i                  clock, all state on the rising edge
//   reset_i                asynchronous active-high reset
//   app                    application interface (slave side)
//   init_calib_complete_o  high once the calibration counter saturates
//   ui_clk_sync_rst_o      UI reset, high for the first cycles after reset
//   dbg_state_o            engine state (0 idle, 1 write, 2 read)
//   dbg_wdf_end_err_o      sticky: a write beat's end flag disagreed with
//                          its position in the burst

// Small synchronous FIFO; ready/full is derived from the occupancy before any
// same-cycle pop, so a push into a full FIFO is refused even while it drains.
module bp_dram_app_model_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   wptr_r, rptr_r;
  logic [cnt_w-1:0]   cnt_r;
  logic               enq, deq;

  assign full_o  = (cnt_r == cnt_w'(els_p));
  assign empty_o = (cnt_r == '0);
  assign enq     = v_i & ~full_o;
  assign deq     = yumi_i & ~empty_o;
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == last_ptr) ? '0 : wptr_r + ptr_w'(1);
      if (deq) rptr_r <= (rptr_r == last_ptr) ? '0 : rptr_r + ptr_w'(1);
      cnt_r <= cnt_r + cnt_w'(enq) - cnt_w'(deq);
    end
  end
endmodule

module bp_dram_app_model #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 64,
  parameter int burst_len_p    = 8,
  parameter int mem_els_p      = 65536,
  parameter int calib_cycles_p = 64,
  parameter int read_latency_p = 4,
  parameter int cmd_fifo_els_p = 4,
  parameter int wdf_fifo_els_p = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_dram_app_model_if.slave    app,
  output logic                  init_calib_complete_o,
  output logic                  ui_clk_sync_rst_o,
  output logic [1:0]            dbg_state_o,
  output logic                  dbg_wdf_end_err_o
);
  localparam int mask_w  = data_width_p / 8;
  localparam int byte_sh = $clog2(mask_w);
  localparam int idx_w   = $clog2(mem_els_p);
  localparam int beat_w  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int cal_w   = $clog2(calib_cycles_p + 1);
  localparam int cmd_w   = 3 + idx_w;
  localparam int wdf_w   = 1 + mask_w + data_width_p;
  localparam logic [beat_w-1:0]       last_beat  = beat_w'(burst_len_p - 1);
  localparam logic [addr_width_p-1:0] burst_mask = addr_width_p'(burst_len_p - 1);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_write = 2'd1,
    st_read  = 2'd2
  } state_e;

  // ---------------- calibration / UI reset ----------------
  logic [cal_w-1:0] calib_cnt_r;
  logic             calib_done;

  assign calib_done = (calib_cnt_r == cal_w'(calib_cycles_p));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)          calib_cnt_r <= '0;
    else if (!calib_done) calib_cnt_r <= calib_cnt_r + cal_w'(1);
  end

  assign init_calib_complete_o = calib_done;
  assign ui_clk_sync_rst_o     = (32'(calib_cnt_r) < 32'd4);

  // ---------------- command and write-data queues ----------------
  logic             cmd_full, cmd_empty, cmd_pop;
  logic [cmd_w-1:0] cmd_in, cmd_out;
  logic [idx_w-1:0] cmd_base_in;
  logic             wdf_full, wdf_empty, wdf_pop;
  logic [wdf_w-1:0] wdf_in, wdf_out;

  // Byte address -> beat index, aligned down to a burst boundary, then
  // reduced modulo the array depth by truncation.
  assign cmd_base_in = idx_w'((app.app_addr_i >> byte_sh) & ~burst_mask);
  assign cmd_in      = {app.app_cmd_i, cmd_base_in};
  assign wdf_in      = {app.app_wdf_end_i, app.app_wdf_mask_i, app.app_wdf_data_i};

  assign app.app_rdy_o     = calib_done & ~cmd_full;
  assign app.app_wdf_rdy_o = calib_done & ~wdf_full;

  bp_dram_app_model_fifo #(.width_p(cmd_w), .els_p(cmd_fifo_els_p)) cmd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (app.app_en_i & app.app_rdy_o),
    .data_i  (cmd_in),
    .yumi_i  (cmd_pop),
    .data_o  (cmd_out),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  bp_dram_app_model_fifo #(.width_p(wdf_w), .els_p(wdf_fifo_els_p)) wdf_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (app.app_wdf_wren_i & app.app_wdf_rdy_o),
    .data_i  (wdf_in),
    .yumi_i  (wdf_pop),
    .data_o  (wdf_out),
    .full_o  (wdf_full),
    .empty_o (wdf_empty)
  );

  logic [2:0]              cmd_q_cmd;
  logic [idx_w-1:0]        cmd_q_base;
  logic                    wdf_q_end;
  logic [mask_w-1:0]       wdf_q_mask;
  logic [data_width_p-1:0] wdf_q_data;

  assign {cmd_q_cmd, cmd_q_base}             = cmd_out;
  assign {wdf_q_end, wdf_q_mask, wdf_q_data} = wdf_out;

  // ---------------- engine FSM ----------------
  state_e            state_r, state_n;
  logic [beat_w-1:0] beat_r, beat_n;
  logic [idx_w-1:0]  base_r, base_n;
  logic              mem_we, rd_issue, is_last;

  assign is_last = (beat_r == last_beat);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= st_idle;
      beat_r  <= '0;
      base_r  <= '0;
    end else begin
      state_r <= state_n;
      beat_r  <= beat_n;
      base_r  <= base_n;
    end
  end

  always_comb begin
    state_n  = state_r;
    beat_n   = beat_r;
    base_n   = base_r;
    cmd_pop  = 1'b0;
    wdf_pop  = 1'b0;
    mem_we   = 1'b0;
    rd_issue = 1'b0;
    case (state_r)
      st_idle: begin
        // No-op commands are popped here and cost one idle cycle.
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          base_n  = cmd_q_base;
          beat_n  = '0;
          if (cmd_q_cmd == 3'd0)      state_n = st_write;
          else if (cmd_q_cmd == 3'd1) state_n = st_read;
        end
      end
      st_write: begin
        if (!wdf_empty) begin
          wdf_pop = 1'b1;
          mem_we  = 1'b1;
          if (is_last) begin
            state_n = st_idle;
            beat_n  = '0;
          end else begin
            beat_n = beat_r + beat_w'(1);
          end
        end
      end
      st_read: begin
        rd_issue = 1'b1;
        if (is_last) begin
          state_n = st_idle;
          beat_n  = '0;
        end else begin
          beat_n = beat_r + beat_w'(1);
        end
      end
      default: state_n = st_idle;
    endcase
  end

  assign dbg_state_o = state_r;

  // ---------------- beat array ----------------
  // Zero at time zero; deliberately untouched by reset so contents survive
  // a controller reset.
  logic [data_width_p-1:0] mem_r [mem_els_p] = '{default: '0};
  logic [idx_w-1:0]        mem_idx;
  logic [data_width_p-1:0] wr_word;

  // Bursts are aligned, so base+beat never crosses a burst; only the array
  // boundary wraps, which the idx_w-bit add provides.
  assign mem_idx = base_r + idx_w'(beat_r);

  // A set mask bit keeps the stored byte.
  always_comb begin
    wr_word = mem_r[mem_idx];
    for (int b = 0; b < mask_w; b++) begin
      if (!wdf_q_mask[b]) wr_word[8*b +: 8] = wdf_q_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_r[mem_idx] <= wr_word;
  end

  // ---------------- write end-flag check ----------------
  logic end_mismatch, end_err_r;

  assign end_mismatch = wdf_pop & (wdf_q_end != is_last);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)           end_err_r <= 1'b0;
    else if (end_mismatch) end_err_r <= 1'b1;
  end

  assign dbg_wdf_end_err_o = end_err_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!end_mismatch)
        else $error("bp_dram_app_model: write beat end flag does not match burst position");
    end
  end

  // ---------------- read return pipeline ----------------
  logic                    rd_v_r [read_latency_p];
  logic                    rd_e_r [read_latency_p];
  logic [data_width_p-1:0] rd_d_r [read_latency_p];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < read_latency_p; i++) begin
        rd_v_r[i] <= 1'b0;
        rd_e_r[i] <= 1'b0;
        rd_d_r[i] <= '0;
      end
    end else begin
      rd_v_r[0] <= rd_issue;
      rd_e_r[0] <= rd_issue & is_last;
      rd_d_r[0] <= rd_issue ? mem_r[mem_idx] : '0;
      for (int i = 1; i < read_latency_p; i++) begin
        rd_v_r[i] <= rd_v_r[i-1];
        rd_e_r[i] <= rd_e_r[i-1];
        rd_d_r[i] <= rd_d_r[i-1];
      end
    end
  end

  assign app.app_rd_data_valid_o = rd_v_r[read_latency_p-1];
  assign app.app_rd_data_end_o   = rd_e_r[read_latency_p-1];
  assign app.app_rd_data_o       = rd_d_r[read_latency_p-1];
endmodule
